bus_timer_resp: RTL and testbench

- Memory-mapped timer peripheral that is the responder on the CPU's shared data bus (Addr, Memread, Memwrite, tristate BUS).
- Decodes a 16-byte window, serves register reads by driving BUS, and captures byte/half/word writes from BUS.
- Runs a prescaled down-counter and raises a level interrupt request on expiry; the top level routes that request toward the CPU interrupt input.

---
 rtl/bus_timer_resp.sv | 190 +++++++++++++++++++
 tb/tb_bus_timer_resp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_timer_resp                                                |
// | Description : Memory-mapped prescaled down-counter timer on a shared        |
// |               tristate CPU data bus, with sticky expiry and level irq.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bus_timer_resp #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 50,
    parameter int unsigned PS_W      = 6
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic        Memread,
    input  logic [1:0]  Memwrite,
    inout  wire  [31:0] BUS,
    output logic        irq
);

    localparam logic [1:0]      c_IDX_CTRL   = 2'd0;
    localparam logic [1:0]      c_IDX_LOAD   = 2'd1;
    localparam logic [1:0]      c_IDX_COUNT  = 2'd2;
    localparam logic [1:0]      c_IDX_STATUS = 2'd3;
    localparam logic [1:0]      c_WR_NONE    = 2'b00;
    localparam logic [1:0]      c_WR_BYTE    = 2'b01;
    localparam logic [1:0]      c_WR_HALF    = 2'b10;
    localparam logic [1:0]      c_WR_WORD    = 2'b11;
    localparam logic [PS_W-1:0] c_PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] c_PS_ONE     = {{(PS_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic            r_en;
    logic            r_auto;
    logic            r_ie;
    logic [31:0]     r_load;
    logic [31:0]     r_count;
    logic            r_exp;
    logic [PS_W-1:0] r_ps;
    logic            r_irq;

    // Decode and write-lane qualification
    logic        w_hit;
    logic [1:0]  w_idx;
    logic [3:0]  w_be;
    logic        w_ctrl_wr;
    logic        w_load_wr;
    logic        w_count_wr;
    logic        w_status_wr;
    logic [31:0] w_load_merged;
    logic [31:0] w_count_merged;

    // Timer datapath
    logic            w_tick;
    logic            w_tick_kill;
    logic            w_tick_eff;
    logic            w_expire;
    logic            w_exp_clr;
    logic            w_en_nxt;
    logic            w_auto_nxt;
    logic            w_ie_nxt;
    logic [31:0]     w_count_nxt;
    logic            w_exp_nxt;
    logic [PS_W-1:0] w_ps_nxt;

    // Read path
    logic        w_drive;
    logic [31:0] w_rdata;

    assign w_hit = (Addr[31:4] == BASE_ADDR[31:4]);
    assign w_idx = Addr[3:2];

    // Misaligned halfword/word writes produce no enables and are dropped.
    always_comb begin
        w_be = 4'b0000;
        if (w_hit) begin
            case (Memwrite)
                c_WR_BYTE: w_be = 4'b0001 << Addr[1:0];
                c_WR_HALF: if (!Addr[0]) w_be = Addr[1] ? 4'b1100 : 4'b0011;
                c_WR_WORD: if (Addr[1:0] == 2'b00) w_be = 4'b1111;
                default:   w_be = 4'b0000;
            endcase
        end
    end

    assign w_ctrl_wr   = (w_idx == c_IDX_CTRL)   && (w_be != 4'b0000);
    assign w_load_wr   = (w_idx == c_IDX_LOAD)   && (w_be != 4'b0000);
    assign w_count_wr  = (w_idx == c_IDX_COUNT)  && (w_be != 4'b0000);
    assign w_status_wr = (w_idx == c_IDX_STATUS) && (w_be != 4'b0000);

    always_comb begin
        w_load_merged  = r_load;
        w_count_merged = r_count;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_load_merged[8*i +: 8]  = BUS[8*i +: 8];
                w_count_merged[8*i +: 8] = BUS[8*i +: 8];
            end
        end
    end

    assign w_tick      = r_en && (r_ps == c_PS_LAST);
    // A CTRL write that clears EN wins over a tick landing in the same cycle.
    assign w_tick_kill = w_ctrl_wr && w_be[0] && !BUS[0];
    assign w_tick_eff  = w_tick && !w_tick_kill;
    assign w_expire    = w_tick_eff && (r_count == 32'd0);
    assign w_exp_clr   = w_status_wr && w_be[0] && BUS[0];

    always_comb begin
        w_en_nxt   = r_en;
        w_auto_nxt = r_auto;
        w_ie_nxt   = r_ie;
        if (w_expire && !r_auto) begin
            w_en_nxt = 1'b0;
        end
        if (w_ctrl_wr && w_be[0]) begin
            w_en_nxt   = BUS[0];
            w_auto_nxt = BUS[1];
            w_ie_nxt   = BUS[2];
        end
    end

    // A bus write to COUNT overrides any decrement or reload from the tick.
    always_comb begin
        w_count_nxt = r_count;
        if (w_tick_eff) begin
            if (r_count != 32'd0) begin
                w_count_nxt = r_count - 32'd1;
            end else if (r_auto) begin
                w_count_nxt = r_load;
            end
        end
        if (w_count_wr) begin
            w_count_nxt = w_count_merged;
        end
    end

    assign w_exp_nxt = (r_exp && !w_exp_clr) || w_expire;

    always_comb begin
        w_ps_nxt = r_ps + c_PS_ONE;
        if (w_ctrl_wr || !r_en || w_tick) begin
            w_ps_nxt = '0;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_ie    <= 1'b0;
            r_load  <= 32'd0;
            r_count <= 32'd0;
            r_exp   <= 1'b0;
            r_ps    <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_en    <= w_en_nxt;
            r_auto  <= w_auto_nxt;
            r_ie    <= w_ie_nxt;
            if (w_load_wr) begin
                r_load <= w_load_merged;
            end
            r_count <= w_count_nxt;
            r_exp   <= w_exp_nxt;
            r_ps    <= w_ps_nxt;
            r_irq   <= r_exp && r_ie;
        end
    end

    assign irq = r_irq;

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            c_IDX_CTRL:   w_rdata = {29'd0, r_ie, r_auto, r_en};
            c_IDX_LOAD:   w_rdata = r_load;
            c_IDX_COUNT:  w_rdata = r_count;
            c_IDX_STATUS: w_rdata = {31'd0, r_exp};
            default:      w_rdata = 32'd0;
        endcase
    end

    // The bus is released while reset is asserted, without waiting for a clock.
    assign w_drive = Memread && w_hit && (Memwrite == c_WR_NONE) && !rst;
    assign BUS     = w_drive ? w_rdata : 32'hzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_timer_resp                                             |
// | Description : Self-checking bench for bus_timer_resp using a queue of       |
// |               expected register/bus values.                                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bus_timer_resp;

    localparam logic [31:0] c_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] c_CTRL   = c_BASE + 32'h0;
    localparam logic [31:0] c_LOAD   = c_BASE + 32'h4;
    localparam logic [31:0] c_COUNT  = c_BASE + 32'h8;
    localparam logic [31:0] c_STATUS = c_BASE + 32'hC;

    logic        clk_50mhz;
    logic        rst;
    logic [31:0] Addr;
    logic        Memread;
    logic [1:0]  Memwrite;
    wire  [31:0] BUS;
    logic        irq;

    logic [31:0] tb_drv;
    logic        tb_drv_en;
    assign BUS = tb_drv_en ? tb_drv : 32'hzzzz_zzzz;

    int checks;
    int failures;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] want;

    bus_timer_resp #(
        .BASE_ADDR(32'hFFFF_0000),
        .PRESCALE (50),
        .PS_W     (6)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .Addr     (Addr),
        .Memread  (Memread),
        .Memwrite (Memwrite),
        .BUS      (BUS),
        .irq      (irq)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    initial begin
        #5ms;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        Addr = a; Memwrite = sz; tb_drv = d; tb_drv_en = 1'b1;
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        Memwrite = 2'b00; tb_drv_en = 1'b0; Addr = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        Addr = a; Memread = 1'b1;
        #1;
        v = BUS;
        Memread = 1'b0; Addr = 32'd0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        rst = 1'b0;
    endtask

    task automatic cmp_reg(input logic [31:0] a, input string name);
        bus_read(a, got);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [31:0] regs [4];
        regs = '{c_CTRL, c_LOAD, c_COUNT, c_STATUS};
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_read(regs[i], got);
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h want=%h", i, got, want);
            end
        end
        exp_q.push_back(32'hzzzz_zzzz);
        Addr = c_COUNT; Memread = 1'b0; #1;
        want = exp_q.pop_front();
        checks++;
        if (BUS !== want) begin
            failures++;
            $display("FAIL z_no_read got=%h want=%h", BUS, want);
        end
        exp_q.push_back(32'hzzzz_zzzz);
        bus_read(32'h0000_1000, got);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL z_miss got=%h want=%h", got, want);
        end
        exp_q.push_back(32'd0);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL reset_irq got=%b want=%b", irq, want[0]);
        end
    endtask

    task automatic test_countdown();
        apply_reset();
        bus_write(c_LOAD, 2'b11, 32'h0000_0003);
        bus_write(c_COUNT, 2'b11, 32'h0000_0002);
        bus_write(c_CTRL, 2'b11, 32'h0000_0007);
        exp_q.push_back(32'd2); cmp_reg(c_COUNT, "cnt_start");
        wait_edges(49);
        exp_q.push_back(32'd2); cmp_reg(c_COUNT, "cnt_before_tick1");
        wait_edges(1);
        exp_q.push_back(32'd1); cmp_reg(c_COUNT, "cnt_tick1");
        wait_edges(50);
        exp_q.push_back(32'd0); cmp_reg(c_COUNT, "cnt_tick2");
        wait_edges(49);
        exp_q.push_back(32'd0); cmp_reg(c_STATUS, "exp_before_expiry");
        wait_edges(1);
        exp_q.push_back(32'd1); cmp_reg(c_STATUS, "exp_at_expiry");
        exp_q.push_back(32'd3); cmp_reg(c_COUNT, "cnt_reload");
        exp_q.push_back(32'd0);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL irq_same_cycle got=%b want=%b", irq, want[0]);
        end
        wait_edges(1);
        exp_q.push_back(32'd1);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL irq_next_cycle got=%b want=%b", irq, want[0]);
        end
    endtask

    task automatic test_lanes();
        apply_reset();
        bus_write(c_LOAD, 2'b11, 32'h1122_3344);
        bus_write(c_BASE + 32'h6, 2'b01, 32'h00AB_0000);
        exp_q.push_back(32'h11AB_3344); cmp_reg(c_LOAD, "byte_lane2");
        bus_write(c_BASE + 32'h5, 2'b10, 32'hFFFF_FFFF);
        exp_q.push_back(32'h11AB_3344); cmp_reg(c_LOAD, "half_misaligned");
        bus_write(c_BASE + 32'h6, 2'b10, 32'hBEEF_0000);
        exp_q.push_back(32'hBEEF_3344); cmp_reg(c_LOAD, "half_upper");
        bus_write(c_BASE + 32'h4, 2'b01, 32'h0000_00C1);
        exp_q.push_back(32'hBEEF_33C1); cmp_reg(c_LOAD, "byte_lane0");
        bus_write(c_BASE + 32'h6, 2'b11, 32'h0000_0000);
        exp_q.push_back(32'hBEEF_33C1); cmp_reg(c_LOAD, "word_misaligned");
        bus_write(c_CTRL, 2'b11, 32'hFFFF_FFF8);
        exp_q.push_back(32'd0); cmp_reg(c_CTRL, "ctrl_unused_bits");
    endtask

    task automatic test_oneshot();
        apply_reset();
        bus_write(c_CTRL, 2'b11, 32'h0000_0005);
        wait_edges(49);
        exp_q.push_back(32'd0); cmp_reg(c_STATUS, "os_before_tick");
        wait_edges(1);
        exp_q.push_back(32'd1); cmp_reg(c_STATUS, "os_exp");
        exp_q.push_back(32'd4); cmp_reg(c_CTRL, "os_en_cleared");
        exp_q.push_back(32'd0); cmp_reg(c_COUNT, "os_count_zero");
        wait_edges(1);
        exp_q.push_back(32'd1);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL os_irq_set got=%b want=%b", irq, want[0]);
        end
        bus_write(c_STATUS, 2'b11, 32'h0000_0000);
        exp_q.push_back(32'd1); cmp_reg(c_STATUS, "w0_no_clear");
        bus_write(c_STATUS, 2'b11, 32'h0000_0001);
        exp_q.push_back(32'd0); cmp_reg(c_STATUS, "w1_clear");
        wait_edges(1);
        exp_q.push_back(32'd0);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL os_irq_clear got=%b want=%b", irq, want[0]);
        end
        bus_write(c_CTRL, 2'b11, 32'h0000_0005);
        wait_edges(49);
        bus_write(c_STATUS, 2'b11, 32'h0000_0001);
        exp_q.push_back(32'd1); cmp_reg(c_STATUS, "clear_vs_expiry");
    endtask

    task automatic test_collisions();
        apply_reset();
        bus_write(c_COUNT, 2'b11, 32'h0000_0001);
        bus_write(c_CTRL, 2'b11, 32'h0000_0001);
        wait_edges(49);
        bus_write(c_CTRL, 2'b11, 32'h0000_0000);
        exp_q.push_back(32'd1); cmp_reg(c_COUNT, "ctrl_kills_tick");
        bus_write(c_COUNT, 2'b11, 32'h0000_0500);
        bus_write(c_CTRL, 2'b11, 32'h0000_0001);
        wait_edges(49);
        bus_write(c_COUNT, 2'b01, 32'h0000_0007);
        exp_q.push_back(32'h0000_0507); cmp_reg(c_COUNT, "count_wr_beats_tick");
        wait_edges(50);
        exp_q.push_back(32'h0000_0506); cmp_reg(c_COUNT, "count_after_wr");
    endtask

    task automatic test_rw_and_reset();
        apply_reset();
        exp_q.push_back(32'hA5A5_5A5A);
        Addr = c_COUNT; Memread = 1'b1; Memwrite = 2'b11;
        tb_drv = 32'hA5A5_5A5A; tb_drv_en = 1'b1;
        #1;
        want = exp_q.pop_front();
        checks++;
        if (BUS !== want) begin
            failures++;
            $display("FAIL rw_no_drive got=%h want=%h", BUS, want);
        end
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        Memread = 1'b0; Memwrite = 2'b00; tb_drv_en = 1'b0; Addr = 32'd0;
        exp_q.push_back(32'hA5A5_5A5A); cmp_reg(c_COUNT, "rw_write_done");
        bus_write(c_COUNT, 2'b11, 32'd1);
        bus_write(c_LOAD, 2'b11, 32'd5);
        bus_write(c_CTRL, 2'b11, 32'h0000_0007);
        wait_edges(101);
        exp_q.push_back(32'd5); cmp_reg(c_COUNT, "pre_rst_count");
        exp_q.push_back(32'd1);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL pre_rst_irq got=%b want=%b", irq, want[0]);
        end
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        want = exp_q.pop_front();
        checks++;
        if (irq !== want[0]) begin
            failures++;
            $display("FAIL async_rst_irq got=%b want=%b", irq, want[0]);
        end
        exp_q.push_back(32'hzzzz_zzzz);
        bus_read(c_COUNT, got);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_rst_bus got=%h want=%h", got, want);
        end
        @(negedge clk_50mhz);
        rst = 1'b0;
        exp_q.push_back(32'd0); cmp_reg(c_COUNT, "post_rst_count");
        exp_q.push_back(32'd0); cmp_reg(c_CTRL, "post_rst_ctrl");
        exp_q.push_back(32'd0); cmp_reg(c_STATUS, "post_rst_status");
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; Addr = 32'd0; Memread = 1'b0; Memwrite = 2'b00;
        tb_drv = 32'd0; tb_drv_en = 1'b0;
        @(negedge clk_50mhz);
        test_reset();
        test_countdown();
        test_lanes();
        test_oneshot();
        test_collisions();
        test_rw_and_reset();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
